// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Holds the FSM state enumeration, the matrix dimensions and the column-strobe helpers.
package keypad_scan_pkg;

  localparam int COL_W = 4;
  localparam int ROW_W = 4;

  // Strobe pattern after reset; every rotation shifts it one column to the left.
  localparam logic [COL_W-1:0] COL_FIRST = 4'b0001;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } scan_state_t;

  function automatic logic [COL_W-1:0] rotate_col(input logic [COL_W-1:0] col);
    return {col[COL_W-2:0], col[COL_W-1]};
  endfunction

  // The lowest set row index wins when several rows are active together.
  function automatic logic [1:0] lowest_row(input logic [ROW_W-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROW_W - 1; i >= 0; i--) begin
      if (rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [1:0] col_index(input logic [COL_W-1:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < COL_W; i++) begin
      if (col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_divider.sv
// Wrap counter 0..DIV-1; tick is high during the last count of every period.
module scan_divider #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotating column strobe, debounced press/release tracking of one key.
// Rows are synchronized, then sampled once per column on the divider's last cycle.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_N);
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_N <= 1);

  scan_state_t      state, state_n;
  logic [3:0]       col_n;
  logic [1:0]       cand_row, cand_n;
  logic [CNT_W-1:0] stable_cnt, cnt_n, cnt_inc;
  logic [3:0]       code_n;
  logic             valid_n, held_n, release_n;
  logic [3:0]       row_meta, row_sync;
  logic             tick;
  logic             cand_bit;

  scan_divider #(
    .DIV(SCAN_DIV)
  ) u_divider (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta    <= '0;
      row_sync    <= '0;
      state       <= SCAN;
      col_out     <= COL_FIRST;
      cand_row    <= '0;
      stable_cnt  <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      row_meta    <= row_in;
      row_sync    <= row_meta;
      state       <= state_n;
      col_out     <= col_n;
      cand_row    <= cand_n;
      stable_cnt  <= cnt_n;
      key_code    <= code_n;
      key_valid   <= valid_n;
      key_held    <= held_n;
      key_release <= release_n;
    end
  end

  assign cand_bit = row_sync[cand_row];
  assign cnt_inc  = stable_cnt + CNT_ONE;

  // Decisions are only taken on a divider tick; the column stays frozen while a key is tracked.
  always_comb begin
    state_n   = state;
    col_n     = col_out;
    cand_n    = cand_row;
    cnt_n     = stable_cnt;
    code_n    = key_code;
    valid_n   = 1'b0;
    held_n    = key_held;
    release_n = 1'b0;

    if (tick) begin
      case (state)
        SCAN: begin
          if (row_sync != '0) begin
            cand_n = lowest_row(row_sync);
            if (SINGLE_SAMPLE) begin
              state_n = HELD;
              cnt_n   = '0;
              valid_n = 1'b1;
              held_n  = 1'b1;
              code_n  = {col_index(col_out), lowest_row(row_sync)};
            end else begin
              state_n = PRESS_DB;
              cnt_n   = CNT_ONE;
            end
          end else begin
            col_n = rotate_col(col_out);
          end
        end

        PRESS_DB: begin
          if (cand_bit) begin
            if (cnt_inc >= CNT_TARGET) begin
              state_n = HELD;
              cnt_n   = '0;
              valid_n = 1'b1;
              held_n  = 1'b1;
              code_n  = {col_index(col_out), cand_row};
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = SCAN;
            cnt_n   = '0;
            col_n   = rotate_col(col_out);
          end
        end

        HELD: begin
          if (!cand_bit) begin
            if (CNT_ONE >= CNT_TARGET) begin
              state_n   = SCAN;
              cnt_n     = '0;
              release_n = 1'b1;
              held_n    = 1'b0;
              col_n     = rotate_col(col_out);
            end else begin
              state_n = RELEASE_DB;
              cnt_n   = CNT_ONE;
            end
          end
        end

        RELEASE_DB: begin
          if (!cand_bit) begin
            if (cnt_inc >= CNT_TARGET) begin
              state_n   = SCAN;
              cnt_n     = '0;
              release_n = 1'b1;
              held_n    = 1'b0;
              col_n     = rotate_col(col_out);
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = HELD;
            cnt_n   = '0;
          end
        end

        default: begin
          state_n = SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad matrix model drives row_in from col_out,
// a sample-level reference model predicts every output each cycle, plus table and hand sequences.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_release;

  // Bit (col*4 + row) set means that key is physically pressed.
  logic [15:0] pressed = '0;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int valid_cnt = 0;
  int rel_cnt   = 0;

  // Reference model: column index, tracked row (-1 = none), press run, release run.
  int         m_col;
  int         m_cand;
  int         m_run;
  int         m_off;
  bit         m_acc;
  logic [3:0] m_code;
  bit         m_valid;
  bit         m_rel;

  typedef struct {
    bit          do_reset;
    logic [15:0] keys;
    int          samples;
    logic [3:0]  exp_col;
    logic [3:0]  exp_code;
    logic        exp_held;
    int          exp_valid;
    int          exp_rel;
  } vec_t;

  vec_t vecs[$];

  keypad_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .DEBOUNCE_N(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (col_out[c] === 1'b1 && pressed[c*4+r]) row_in[r] = 1'b1;
      end
    end
  end

  task automatic modelReset();
    m_col   = 0;
    m_cand  = -1;
    m_run   = 0;
    m_off   = 0;
    m_acc   = 0;
    m_code  = 4'd0;
    m_valid = 0;
    m_rel   = 0;
  endtask

  task automatic modelAccept();
    m_acc   = 1;
    m_valid = 1;
    m_off   = 0;
    m_code  = 4'(m_col * 4 + m_cand);
  endtask

  // One row sample of the currently strobed column, applying the debounce rules directly.
  task automatic modelSample();
    logic [3:0] rows;
    for (int r = 0; r < 4; r++) rows[r] = pressed[m_col*4+r];
    m_valid = 0;
    m_rel   = 0;
    if (m_cand < 0) begin
      if (rows != 4'd0) begin
        for (int r = 3; r >= 0; r--) if (rows[r]) m_cand = r;
        m_run = 1;
        if (m_run >= DB) modelAccept();
      end else begin
        m_col = (m_col + 1) % 4;
      end
    end else if (!m_acc) begin
      if (rows[m_cand]) begin
        m_run++;
        if (m_run >= DB) modelAccept();
      end else begin
        m_cand = -1;
        m_col  = (m_col + 1) % 4;
      end
    end else begin
      if (rows[m_cand]) begin
        m_off = 0;
      end else begin
        m_off++;
        if (m_off >= DB) begin
          m_rel  = 1;
          m_acc  = 0;
          m_cand = -1;
          m_col  = (m_col + 1) % 4;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = {col_out, key_code, key_held, key_valid, key_release};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got col=%b code=%b held=%b valid=%b rel=%b, expected col=%b code=%b held=%b valid=%b rel=%b",
               name, got[10:7], got[6:3], got[2], got[1], got[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // One clock: advance the model on sample edges, then compare every output.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (cyc % SCAN_DIV == 0) begin
      modelSample();
    end else begin
      m_valid = 0;
      m_rel   = 0;
    end
    #1;
    if (key_valid === 1'b1) valid_cnt++;
    if (key_release === 1'b1) rel_cnt++;
    checkOutput($sformatf("cycle%0d", cyc), {4'b0001 << m_col, m_code, m_acc, m_valid, m_rel});
  endtask

  task automatic resetDut();
    rst     = 1'b0;
    pressed = '0;
    @(posedge clk);
    #1;
    checkOutput("reset_edge", {4'b0001, 4'b0000, 3'b000});
    @(posedge clk);
    #1;
    rst       = 1'b1;
    cyc       = 0;
    valid_cnt = 0;
    rel_cnt   = 0;
    modelReset();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.do_reset) resetDut();
    pressed = v.keys;
    repeat (v.samples * SCAN_DIV) step();
  endtask

  function automatic vec_t mk(input bit rs, input logic [15:0] keys, input int n,
                              input logic [3:0] col, input logic [3:0] code, input logic held,
                              input int nv, input int nr);
    vec_t v;
    v.do_reset  = rs;
    v.keys      = keys;
    v.samples   = n;
    v.exp_col   = col;
    v.exp_code  = code;
    v.exp_held  = held;
    v.exp_valid = nv;
    v.exp_rel   = nr;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Idle scan, long press with extra rows, bounced release, short bounce press, two-row press.
    vecs.push_back(mk(1, 16'h0000,  3, 4'b1000, 4'b0000, 1'b0, 0, 0));
    vecs.push_back(mk(1, 16'h0200, 20, 4'b0100, 4'b1001, 1'b1, 1, 0));
    vecs.push_back(mk(0, 16'h0300,  3, 4'b0100, 4'b1001, 1'b1, 1, 0));
    vecs.push_back(mk(0, 16'h0000,  1, 4'b0100, 4'b1001, 1'b1, 1, 0));
    vecs.push_back(mk(0, 16'h0200,  1, 4'b0100, 4'b1001, 1'b1, 1, 0));
    vecs.push_back(mk(0, 16'h0000,  2, 4'b0100, 4'b1001, 1'b1, 1, 0));
    vecs.push_back(mk(0, 16'h0000,  1, 4'b1000, 4'b1001, 1'b0, 1, 1));
    vecs.push_back(mk(1, 16'h0200,  3, 4'b0100, 4'b0000, 1'b0, 0, 0));
    vecs.push_back(mk(0, 16'h0200,  1, 4'b0100, 4'b0000, 1'b0, 0, 0));
    vecs.push_back(mk(0, 16'h0000,  1, 4'b1000, 4'b0000, 1'b0, 0, 0));
    vecs.push_back(mk(1, 16'h0009,  3, 4'b0001, 4'b0000, 1'b1, 1, 0));
    vecs.push_back(mk(0, 16'h0001,  4, 4'b0001, 4'b0000, 1'b1, 1, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkValue($sformatf("vec%0d_state", i), 32'({col_out, key_code, key_held}),
                 32'({vecs[i].exp_col, vecs[i].exp_code, vecs[i].exp_held}));
      checkValue($sformatf("vec%0d_valid_count", i), valid_cnt, vecs[i].exp_valid);
      checkValue($sformatf("vec%0d_release_count", i), rel_cnt, vecs[i].exp_rel);
    end

    // Reset while a key is held: outputs clear on the reset edge, no release pulse.
    resetDut();
    pressed = 16'h0200;
    repeat (10 * SCAN_DIV) step();
    checkValue("held_before_reset", 32'(key_held), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_in_held", {4'b0001, 4'b0000, 3'b000});
    @(posedge clk);
    #1;
    checkOutput("reset_in_held_2", {4'b0001, 4'b0000, 3'b000});
    rst       = 1'b1;
    pressed   = '0;
    cyc       = 0;
    valid_cnt = 0;
    rel_cnt   = 0;
    modelReset();
    repeat (2 * SCAN_DIV) step();

    // Random key activity against the reference model.
    resetDut();
    repeat (60) begin
      case ($urandom_range(0, 3))
        0:       pressed = '0;
        1, 2:    pressed = 16'(1) << $urandom_range(0, 15);
        default: pressed = 16'($urandom) & 16'($urandom);
      endcase
      repeat ($urandom_range(1, 6) * SCAN_DIV) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each column strobe is held (min 2).
REQ-002 Parameter DEBOUNCE_N, default 4, consecutive identical samples required to accept a press or release (min 1).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 row_in  input  4  keypad row sense, 1 = pressed on the currently strobed column.
REQ-006 col_out  output  4  one-hot column strobe, active-high.
REQ-007 key_code  output  4  accepted key index, {col[1:0], row[1:0]}; held stable until the next accepted press.
REQ-008 key_valid  output  1  one-cycle pulse on press acceptance.
REQ-009 key_held  output  1  high from press acceptance until release acceptance.
REQ-010 key_release  output  1  one-cycle pulse on release acceptance.

Function
REQ-011 A divider counter shall count 0..SCAN_DIV-1 and wrap; row_in shall be sampled once per column, on the last divider cycle (count = SCAN_DIV-1).
REQ-012 row_in shall pass through a two-flop synchronizer before sampling; synchronizer latency is excluded from SCAN_DIV.
REQ-013 States: SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-014 SCAN: col_out rotates 0001->0010->0100->1000->0001, advancing on divider wrap; a nonzero sample latches the candidate key (lowest set row index wins) and enters PRESS_DB with column frozen.
REQ-015 PRESS_DB: column frozen; each sample whose candidate-row bit is 1 increments the stable counter; when it reaches DEBOUNCE_N -> HELD. A sample with the bit 0 -> SCAN, advancing to the next column.
REQ-016 Entry to HELD shall assert key_valid for exactly one cycle, update key_code the same cycle, and raise key_held.
REQ-017 HELD: column frozen; a sample with candidate-row bit 0 enters RELEASE_DB with stable counter = 1; other rows pressed meanwhile are ignored.
REQ-018 RELEASE_DB: bit-0 samples increment the counter; reaching DEBOUNCE_N -> SCAN with a one-cycle key_release pulse, key_held low and the column advanced; a bit-1 sample -> HELD with no pulse.
REQ-019 With DEBOUNCE_N = 1, press acceptance shall occur on the first sample (SCAN -> HELD directly, still one key_valid pulse).
REQ-020 key_valid and key_release shall never be high in the same cycle; key_code shall not change except on key_valid.
REQ-021 Two or more keys never produce simultaneous events; only one key is tracked at a time.

Reset
REQ-022 While rst = 0 at a rising edge: state SCAN, col_out = 0001, divider = 0, stable counter = 0, synchronizer = 0, key_code = 0, key_valid = 0, key_held = 0, key_release = 0.
REQ-023 Reset asserted in HELD or RELEASE_DB shall not emit key_release; key_held shall drop on the reset edge.

Structure
REQ-024 A shared package shall hold the state enumeration, the column and row widths (4) and the one-hot column rotate constant.
REQ-025 One sub-module, scan_divider (parameterized wrap counter with a tick output), shall be instantiated; the FSM shall stay in keypad_scan.

Verification (SCAN_DIV = 4, DEBOUNCE_N = 3 unless stated)
REQ-026 Reset release, no keys -> col_out cycles 0001,0010,0100,1000 every 4 clocks; key_valid never asserts.
REQ-027 Key col 2 row 1 held for 20 samples -> exactly one key_valid, key_code = 4'b1001, key_held high, col_out frozen at 0100.
REQ-028 Key pressed for 2 samples then released (bounce) -> no key_valid; scanning resumes at col_out = 1000.
REQ-029 Release with one bounce sample (0,1,0,0,0) -> returns to HELD after the bounce, then exactly one key_release after three consecutive 0 samples; key_code still 4'b1001.
REQ-030 Rows 0 and 3 pressed together on col 0 -> key_code = 4'b0000; releasing row 3 alone causes no event.
REQ-031 rst = 0 while in HELD -> next cycle all outputs at reset values, col_out = 0001, no key_release pulse.
